// File: rtl/debounce_sync_pkg.sv
// ---------------------------------------------------------------------------
// debounce_sync_pkg: shared defaults, state encoding and parameter check helper
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package debounce_sync_pkg;

  localparam int DEB_STABLE_DEFAULT = 16;
  localparam int DEB_CNT_W_DEFAULT  = 5;

  // The debounced level is itself the state: low or high idle.
  localparam logic [0:0] ST_IDLE_LO = 1'b0;
  localparam logic [0:0] ST_IDLE_HI = 1'b1;

  typedef struct packed {
    logic rise;
    logic fall;
  } deb_edge_t;

  function automatic bit deb_cnt_w_ok(input int stable, input int cnt_w);
    return (stable >= 1) && ((2 ** cnt_w) > (stable - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_sync_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff: two-flop synchroniser for one asynchronous level, reset to 0
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/debounce_sync.sv
// ---------------------------------------------------------------------------
// debounce_sync: synchronise a raw level, require STABLE_CYCLES of agreement
// before the output follows, and strobe rise/fall on each output change.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module debounce_sync
  import debounce_sync_pkg::*;
#(
  parameter int STABLE_CYCLES = DEB_STABLE_DEFAULT,
  parameter int CNT_W         = DEB_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  output logic y,
  output logic rise,
  output logic fall
);

  generate
    if (!deb_cnt_w_ok(STABLE_CYCLES, CNT_W)) begin : g_bad_cnt_w
      $error("debounce_sync: need STABLE_CYCLES>=1 and 2**CNT_W > STABLE_CYCLES-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);

  logic a_sync;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (a_raw),
    .q   (a_sync)
  );

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       y_q, y_d;
  deb_edge_t        edge_q, edge_d;

  // Any agreement between a_sync and y restarts the stability count.
  always_comb begin
    cnt_d  = '0;
    y_d    = y_q;
    edge_d = '{rise: 1'b0, fall: 1'b0};
    if (a_sync != y_q[0]) begin
      if (cnt_q == CNT_TERM) begin
        y_d         = a_sync ? ST_IDLE_HI : ST_IDLE_LO;
        edge_d.rise = a_sync;
        edge_d.fall = ~a_sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      y_q    <= ST_IDLE_LO;
      edge_q <= '{rise: 1'b0, fall: 1'b0};
    end else begin
      cnt_q  <= cnt_d;
      y_q    <= y_d;
      edge_q <= edge_d;
    end
  end

  assign y    = y_q[0];
  assign rise = edge_q.rise;
  assign fall = edge_q.fall;

endmodule

`default_nettype wire
